// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and frame constants.
// Frame: MAGIC, LEN_lo, LEN_hi, 4*N data bytes (first byte of each word lands in bits [7:0]), CSUM.
package boot_pkg;

    typedef enum logic [2:0] {
        S_MAGIC = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } boot_state_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    // The byte stream is only accepted while a frame is still being parsed.
    function automatic logic is_loading(input boot_state_e s);
        return (s != S_RUN) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes into a 32-bit little-endian word; o_word_vld flags the 4th byte combinationally.
// Zero latency to the caller, which registers the word; no backpressure (one byte per cycle).
module boot_word_packer
    import boot_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        // Completed word includes the byte arriving this cycle in the top lane.
        o_word_dat        = word_q;
        o_word_dat[31:24] = i_byte_dat;
        o_word_vld        = i_byte_vld && (byte_idx_q == 2'd3);
        if (i_clr) begin
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
        end else if (i_byte_vld) begin
            word_d[{byte_idx_q, 3'b000} +: 8] = i_byte_dat;
            byte_idx_d                        = byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image, writes it to imem as LE words, releases core reset on good checksum.
// One cycle from 4th byte to write pulse; no backpressure inside a frame, ready drops once run/error.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          BASE_ADDR = 0,
    parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reload,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_rstn,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned LIMIT = (32'd1 << ADDR_W) - 32'(BASE_ADDR);

    boot_state_e       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              rstn_q, rstn_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic              pk_byte_vld;
    logic              pk_word_vld;
    logic [31:0]       pk_word_dat;

    assign accept      = i_rx_valid && rdy_q;
    assign pk_byte_vld = accept && (state_q == S_DATA) && !i_reload;

    boot_word_packer u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_reload),
        .i_byte_vld (pk_byte_vld),
        .i_byte_dat (i_rx_data),
        .o_word_vld (pk_word_vld),
        .o_word_dat (pk_word_dat)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_full   = {i_rx_data, len_q[7:0]};

        case (state_q)
            S_MAGIC: if (accept && (i_rx_data == MAGIC)) state_d = S_LEN0;
            S_LEN0: if (accept) begin
                len_d[7:0] = i_rx_data;
                state_d    = S_LEN1;
            end
            S_LEN1: if (accept) begin
                len_d[15:8] = i_rx_data;
                if (32'(len_full) > LIMIT)  state_d = S_ERR;
                else if (len_full == 16'd0) state_d = S_CSUM;
                else                        state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                csum_d = csum_q ^ i_rx_data;
                if (pk_word_vld) begin
                    we_d       = 1'b1;
                    addr_d     = ADDR_W'(32'(BASE_ADDR) + 32'(word_idx_q));
                    wdata_d    = pk_word_dat;
                    word_idx_d = word_idx_q + 16'd1;
                    if (word_idx_q == len_q - 16'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: if (accept) state_d = (i_rx_data == csum_q) ? S_RUN : S_ERR;
            default: ;
        endcase

        // Reload wins over anything the current byte would have done, including a pending write.
        if (i_reload) begin
            state_d    = S_MAGIC;
            len_d      = 16'd0;
            word_idx_d = 16'd0;
            csum_d     = 8'd0;
            we_d       = 1'b0;
        end

        rdy_d  = is_loading(state_d);
        rstn_d = (state_d == S_RUN);
        done_d = (state_d == S_RUN);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_MAGIC;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            csum_q     <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            rdy_q      <= 1'b0;
            rstn_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdy_q      <= rdy_d;
            rstn_q     <= rstn_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_rx_ready   = rdy_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_core_rstn  = rstn_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus random frames, writes checked by a scoreboard.
module tb_imem_boot_loader;

    typedef logic [7:0] bq_t[$];

    localparam int DEPTH = 1024;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_reload;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       o_rx_ready;
    logic       o_imem_we;
    logic [9:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic       o_core_rstn;
    logic       o_done;
    logic       o_err;

    imem_boot_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_reload     (i_reload),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_rx_ready   (o_rx_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_core_rstn  (o_core_rstn),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    bit          gaps_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge i_clk) begin
        if (o_imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected none", o_imem_addr, o_imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(o_imem_addr), e[63:32]);
                chk("wr_data", o_imem_wdata, e[31:0]);
            end
        end
    end

    // Reference model: parse the byte list as a frame; push the writes it implies.
    // Returns 0 = frame incomplete, 1 = loaded ok, 2 = error.
    function automatic int model(input bq_t bs);
        int i = 0;
        int n;
        logic [7:0] cs = 8'd0;
        while (i < bs.size() && bs[i] != 8'hA5) i++;
        if (i + 3 > bs.size()) return 0;
        n = int'(bs[i+1]) + 256 * int'(bs[i+2]);
        i += 3;
        if (n > DEPTH) return 2;
        for (int w = 0; w < n; w++) begin
            if (i + 4 > bs.size()) return 0;
            exp_q.push_back({32'(w), bs[i+3], bs[i+2], bs[i+1], bs[i]});
            cs = cs ^ bs[i] ^ bs[i+1] ^ bs[i+2] ^ bs[i+3];
            i += 4;
        end
        if (i >= bs.size()) return 0;
        return (bs[i] == cs) ? 1 : 2;
    endfunction

    function automatic bq_t make_frame(input logic [31:0] words[$], input logic [7:0] csum_flip);
        bq_t f;
        logic [7:0] cs = 8'd0;
        f.push_back(8'hA5);
        f.push_back(8'(words.size()));
        f.push_back(8'(words.size() >> 8));
        foreach (words[k]) begin
            for (int b = 0; b < 4; b++) begin
                f.push_back(words[k][8*b +: 8]);
                cs ^= words[k][8*b +: 8];
            end
        end
        f.push_back(cs ^ csum_flip);
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge i_clk);
        if (gaps_en) begin
            int k = $urandom_range(0, 2);
            if (k > 0) begin
                i_rx_valid = 1'b0;
                repeat (k) @(negedge i_clk);
            end
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (o_rx_ready !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: o_rx_ready %b, expected 1", o_rx_ready);
        end
        @(posedge i_clk);
    endtask

    task automatic send_bytes(input bq_t bs);
        foreach (bs[k]) send_byte(bs[k]);
    endtask

    task automatic idle(input int cycles);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (cycles) @(negedge i_clk);
    endtask

    task automatic check_status(input string tag, input int st);
        chk({tag, "_done"}, 32'(o_done), 32'(st == 1));
        chk({tag, "_err"}, 32'(o_err), 32'(st == 2));
        chk({tag, "_rstn"}, 32'(o_core_rstn), 32'(st == 1));
        chk({tag, "_rdy"}, 32'(o_rx_ready), 32'(st == 0));
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reload_pulse(input string tag);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_reload   = 1'b1;
        @(negedge i_clk);
        i_reload = 1'b0;
        chk({tag, "_rl_rstn"}, 32'(o_core_rstn), 32'd0);
        chk({tag, "_rl_rdy"}, 32'(o_rx_ready), 32'd1);
        chk({tag, "_rl_done"}, 32'(o_done), 32'd0);
        chk({tag, "_rl_err"}, 32'(o_err), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bq_t bs);
        int st;
        st = model(bs);
        send_bytes(bs);
        idle(3);
        check_status(tag, st);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f1, f2, b, part;
        int st;
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        i_rst = 1'b1; i_reload = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;

        repeat (3) @(negedge i_clk);
        chk("rst_rdy", 32'(o_rx_ready), 32'd0);
        chk("rst_we", 32'(o_imem_we), 32'd0);
        chk("rst_addr", 32'(o_imem_addr), 32'd0);
        chk("rst_wdata", o_imem_wdata, 32'd0);
        chk("rst_rstn", 32'(o_core_rstn), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_rdy", 32'(o_rx_ready), 32'd1);

        // Test 1, with an exact check that core reset releases right after the CSUM byte.
        st = model(f1);
        send_bytes(f1);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("t1_rstn_next_cycle", 32'(o_core_rstn), 32'd1);
        repeat (2) @(negedge i_clk);
        check_status("t1", st);
        reload_pulse("t1");

        f2 = f1;
        f2[11] = 8'h2B;
        run_frame("t2", f2);
        reload_pulse("t2");

        b = '{8'h00, 8'hFF, 8'h5A};
        run_frame("t3", {b, f1});
        reload_pulse("t3");

        run_frame("t4a", '{8'hA5, 8'h00, 8'h00, 8'h00});
        reload_pulse("t4a");
        run_frame("t4b", '{8'hA5, 8'h00, 8'h00, 8'h01});
        reload_pulse("t4b");

        st = model('{8'hA5, 8'h01, 8'h04});
        send_bytes('{8'hA5, 8'h01, 8'h04});
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("t5_err_immediate", 32'(o_err), 32'd1);
        repeat (2) @(negedge i_clk);
        check_status("t5", st);
        reload_pulse("t5");

        // Test 6: abort mid-frame by reload, then by reset, each followed by a clean resend.
        gaps_en = 1'b1;
        part = f1[0:7];
        st = model(part);
        send_bytes(part);
        reload_pulse("t6a");
        idle(4);
        chk("t6a_no_more_writes", 32'(exp_q.size()), 32'd0);
        run_frame("t6a_resend", f1);
        reload_pulse("t6a_resend");

        st = model(part);
        send_bytes(part);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t6b_rst_rstn", 32'(o_core_rstn), 32'd0);
        chk("t6b_rst_we", 32'(o_imem_we), 32'd0);
        i_rst = 1'b0;
        idle(3);
        chk("t6b_no_more_writes", 32'(exp_q.size()), 32'd0);
        run_frame("t6b_resend", f1);
        reload_pulse("t6b_resend");

        // Random frames: leading junk, random length and data, occasional corrupted checksum.
        for (int it = 0; it < 10; it++) begin
            logic [31:0] words[$];
            bq_t junk;
            int nw = $urandom_range(0, 6);
            gaps_en = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                junk.push_back(j);
            end
            repeat (nw) words.push_back($urandom);
            run_frame("rnd", {junk, make_frame(words, ($urandom_range(0, 2) == 0) ? 8'h10 : 8'h00)});
            reload_pulse("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
